// File: rtl/raizing_snd_pkg.sv
// Shared types and constants for the Raizing sound-ROM SDRAM arbiter.
package raizing_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Requester indices; also the encoding of the grant/last-grant bit
  localparam logic REQ_Z80 = 1'b0;
  localparam logic REQ_PCM = 1'b1;

  // Default SDRAM word offsets of the two ROM regions
  localparam logic [21:0] Z80_BASE_DEF = 22'h000000;
  localparam logic [21:0] PCM_BASE_DEF = 22'h010000;

  // Pick the addressed byte out of a 16-bit SDRAM word
  function automatic logic [7:0] byte_sel(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/raizing_snd_rr_arb.sv
// Two-way round-robin grant. Combinational pick, last-grant register updated
// only when the grant is actually taken (top FSM in IDLE with a pending request).
module raizing_snd_rr_arb
  import raizing_snd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_pend,
  input  logic       i_take,
  output logic       o_gnt
);

  logic r_last;

  // Lone pending requester wins; on a tie the one not granted last wins
  always_comb begin
    o_gnt = REQ_PCM;
    if (i_pend[REQ_Z80] && !i_pend[REQ_PCM])
      o_gnt = REQ_Z80;
    else if (i_pend[REQ_Z80] && i_pend[REQ_PCM])
      o_gnt = ~r_last;
  end

  // Remember who was granted; reset to Z80 so PCM wins the first tie
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_last <= REQ_Z80;
    else if (i_take) r_last <= o_gnt;
  end

endmodule

// File: rtl/raizing_snd_rom_arb.sv
// Raizing sound ROM arbiter: serialises Z80 and OKI6295 ROM fetches onto one
// SDRAM request/ack/data-strobe channel, one latched byte per requester.
// Build option: RAIZING_SNDARB_HIT_EN keeps a requester's latched byte valid
// while its cs is low, so re-asserting cs on the same address hits at once.
module raizing_snd_rom_arb
  import raizing_snd_pkg::*;
#(
  parameter int               Z80_AW   = 17,
  parameter int               PCM_AW   = 20,
  parameter int               SD_AW    = 22,
  parameter logic [SD_AW-1:0] Z80_BASE = SD_AW'(Z80_BASE_DEF),
  parameter logic [SD_AW-1:0] PCM_BASE = SD_AW'(PCM_BASE_DEF)
)(
  input  logic              CLK96,
  input  logic              RESET96,
  input  logic              Z80_CS,
  input  logic [Z80_AW-1:0] Z80_ADDR,
  output logic [7:0]        Z80_DOUT,
  output logic              Z80_OK,
  input  logic              PCM_CS,
  input  logic [PCM_AW-1:0] PCM_ADDR,
  output logic [7:0]        PCM_DOUT,
  output logic              PCM_OK,
  output logic              SD_REQ,
  output logic [SD_AW-1:0]  SD_ADDR,
  input  logic              SD_ACK,
  input  logic              SD_DST,
  input  logic [15:0]       SD_DATA,
  output logic              BUSY
);

`ifdef RAIZING_SNDARB_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  state_t              r_state;
  logic                r_gnt;
  logic                r_sd_req;
  logic [SD_AW-1:0]    r_sd_addr;
  logic [Z80_AW-1:0]   r_z80_addr;
  logic [7:0]          r_z80_data;
  logic                r_z80_vld;
  logic [PCM_AW-1:0]   r_pcm_addr;
  logic [7:0]          r_pcm_data;
  logic                r_pcm_vld;

  logic                w_z80_hit, w_pcm_hit;
  logic [1:0]          w_pend;
  logic                w_take, w_gnt;
  logic [SD_AW-1:0]    w_z80_sd, w_pcm_sd;
  logic                w_dst_now;
  logic [7:0]          w_byte;

  // A hit needs no SDRAM traffic; anything else with cs high is pending
  assign w_z80_hit         = Z80_CS && r_z80_vld && (Z80_ADDR == r_z80_addr);
  assign w_pcm_hit         = PCM_CS && r_pcm_vld && (PCM_ADDR == r_pcm_addr);
  assign w_pend[REQ_Z80]   = Z80_CS && !w_z80_hit;
  assign w_pend[REQ_PCM]   = PCM_CS && !w_pcm_hit;
  assign w_take            = (r_state == ST_IDLE) && (|w_pend);

  // Word address = region base + byte address / 2, wrapping at SD_AW bits
  assign w_z80_sd = Z80_BASE + SD_AW'(Z80_ADDR >> 1);
  assign w_pcm_sd = PCM_BASE + SD_AW'(PCM_ADDR >> 1);

  // Data strobe counts only after an ack (same-cycle ack+dst in REQ included)
  assign w_dst_now = SD_DST && ((r_state == ST_WAIT) || (r_state == ST_REQ && SD_ACK));
  assign w_byte    = byte_sel(SD_DATA, (r_gnt == REQ_PCM) ? r_pcm_addr[0] : r_z80_addr[0]);

  assign Z80_OK   = w_z80_hit;
  assign Z80_DOUT = r_z80_data;
  assign PCM_OK   = w_pcm_hit;
  assign PCM_DOUT = r_pcm_data;
  assign SD_REQ   = r_sd_req;
  assign SD_ADDR  = r_sd_addr;
  assign BUSY     = (r_state != ST_IDLE);

  raizing_snd_rr_arb u_arb (
    .i_clk  (CLK96),
    .i_rst  (RESET96),
    .i_pend (w_pend),
    .i_take (w_take),
    .o_gnt  (w_gnt)
  );

  // Transaction FSM plus the per-requester address/data/valid records
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_state    <= ST_IDLE;
      r_gnt      <= REQ_Z80;
      r_sd_req   <= 1'b0;
      r_sd_addr  <= '0;
      r_z80_addr <= '0;
      r_z80_data <= '0;
      r_z80_vld  <= 1'b0;
      r_pcm_addr <= '0;
      r_pcm_data <= '0;
      r_pcm_vld  <= 1'b0;
    end else begin
      // Without the hit option a byte only lives while its cs stays high
      if (!HIT_EN && !Z80_CS) r_z80_vld <= 1'b0;
      if (!HIT_EN && !PCM_CS) r_pcm_vld <= 1'b0;

      // Store under the address latched at grant, even if the requester moved on
      if (w_dst_now) begin
        if (r_gnt == REQ_PCM) begin
          r_pcm_data <= w_byte;
          r_pcm_vld  <= 1'b1;
        end else begin
          r_z80_data <= w_byte;
          r_z80_vld  <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: if (w_take) begin
          r_gnt    <= w_gnt;
          r_sd_req <= 1'b1;
          r_state  <= ST_REQ;
          // Invalidate on re-latch so stale data never matches the new address
          if (w_gnt == REQ_PCM) begin
            r_pcm_addr <= PCM_ADDR;
            r_pcm_vld  <= 1'b0;
            r_sd_addr  <= w_pcm_sd;
          end else begin
            r_z80_addr <= Z80_ADDR;
            r_z80_vld  <= 1'b0;
            r_sd_addr  <= w_z80_sd;
          end
        end
        ST_REQ: if (SD_ACK) begin
          r_sd_req <= 1'b0;
          r_state  <= w_dst_now ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: if (SD_DST) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raizing_snd_rom_arb.sv
// Self-checking bench for raizing_snd_rom_arb: directed vector table, hand
// sequences for arbitration/abort/reset corners, then randomized traffic
// checked against a behavioural ROM model.
module tb_raizing_snd_rom_arb;

  localparam logic [21:0] ZB = 22'h000000;
  localparam logic [21:0] PB = 22'h010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        z_cs, p_cs;
  logic [16:0] z_addr;
  logic [19:0] p_addr;
  logic [7:0]  z_dout, p_dout;
  logic        z_ok, p_ok;
  logic        sd_req, sd_ack, sd_dst, busy;
  logic [21:0] sd_addr;
  logic [15:0] sd_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int dst_cyc  = -100;

  // SDRAM responder state (bench side)
  int          rs_phase = 0;
  int          rs_cnt   = 0;
  logic [15:0] rs_data  = '0;
  bit          resp_en  = 1'b1;
  bit          fixed_en = 1'b1;
  bit          rand_dly = 1'b0;
  logic [15:0] fixed_data = '0;
  int          ack_dly  = 1;
  int          dst_dly  = 1;
  logic [21:0] req_log[$];

  typedef struct {
    bit          pcm;
    logic [19:0] addr;
    logic [15:0] data;
    int          ack;
    int          dst;
    logic [21:0] exp_sa;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[6];

  raizing_snd_rom_arb dut (
    .CLK96(clk), .RESET96(rst),
    .Z80_CS(z_cs), .Z80_ADDR(z_addr), .Z80_DOUT(z_dout), .Z80_OK(z_ok),
    .PCM_CS(p_cs), .PCM_ADDR(p_addr), .PCM_DOUT(p_dout), .PCM_OK(p_ok),
    .SD_REQ(sd_req), .SD_ADDR(sd_addr), .SD_ACK(sd_ack), .SD_DST(sd_dst),
    .SD_DATA(sd_data), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // ROM contents as seen through SDRAM: arbitrary fixed function of word address
  function automatic logic [15:0] mem_word(input logic [21:0] w);
    logic [31:0] t;
    t = 32'(w) * 32'd40503 + 32'h1D2B;
    return t[23:8];
  endfunction

  function automatic logic [7:0] exp_z80(input logic [16:0] a);
    logic [15:0] d;
    d = mem_word(ZB + 22'(a >> 1));
    return a[0] ? d[15:8] : d[7:0];
  endfunction

  function automatic logic [7:0] exp_pcm(input logic [19:0] a);
    logic [15:0] d;
    d = mem_word(PB + 22'(a >> 1));
    return a[0] ? d[15:8] : d[7:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Advance one clock; returns 1 time unit after the edge with SDRAM inputs driven
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    sd_ack  = 1'b0;
    sd_dst  = 1'b0;
    sd_data = 16'($urandom);
    if (rs_phase == 2) begin
      rs_cnt--;
      if (rs_cnt == 0) begin
        sd_dst = 1'b1; sd_data = rs_data; dst_cyc = cyc; rs_phase = 0;
      end
    end else begin
      if (rs_phase == 0 && sd_req && resp_en) begin
        if (rand_dly) begin
          ack_dly = $urandom_range(0, 3);
          dst_dly = $urandom_range(0, 3);
        end
        rs_data = fixed_en ? fixed_data : mem_word(sd_addr);
        req_log.push_back(sd_addr);
        rs_cnt   = ack_dly;
        rs_phase = 1;
      end
      if (rs_phase == 1) begin
        if (rs_cnt == 0) begin
          sd_ack = 1'b1;
          if (dst_dly == 0) begin
            sd_dst = 1'b1; sd_data = rs_data; dst_cyc = cyc; rs_phase = 0;
          end else begin
            rs_cnt = dst_dly; rs_phase = 2;
          end
        end else rs_cnt--;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; z_cs = 1'b0; p_cs = 1'b0;
    rs_phase = 0; resp_en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!sd_req && n < 50) begin step(); n++; end
    chk(nm, 32'(sd_req), 32'd1);
  endtask

  task automatic wait_ok(input bit pcm, input string nm);
    int n;
    n = 0;
    while (!(pcm ? p_ok : z_ok) && n < 60) begin step(); n++; end
    chk(nm, 32'(pcm ? p_ok : z_ok), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    fixed_en = 1'b1; fixed_data = v.data; ack_dly = v.ack; dst_dly = v.dst;
    if (v.pcm) begin p_addr = v.addr; p_cs = 1'b1; end
    else begin z_addr = v.addr[16:0]; z_cs = 1'b1; end
    #1;
    wait_req({s, "_req"});
    chk({s, "_sdaddr"}, 32'(sd_addr), 32'(v.exp_sa));
    wait_ok(v.pcm, {s, "_ok"});
    chk({s, "_ok_latency"}, 32'(cyc - dst_cyc), 32'd1);
    chk({s, "_dout"}, 32'(v.pcm ? p_dout : z_dout), 32'(v.exp_dout));
    chk({s, "_idle"}, 32'(busy), 32'd0);
    z_cs = 1'b0; p_cs = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int n, zw, pw;
    logic [16:0] zprev;
    logic [19:0] pprev;

    vecs[0] = '{1'b0, 20'h00101, 16'hBEEF, 2, 3, 22'h000080, 8'hBE};
    vecs[1] = '{1'b0, 20'h1FFFF, 16'h1357, 0, 1, 22'h00FFFF, 8'h13};
    vecs[2] = '{1'b1, 20'h00010, 16'hA55A, 1, 2, 22'h010008, 8'h5A};
    vecs[3] = '{1'b1, 20'hFFFFF, 16'hC0DE, 3, 1, 22'h08FFFF, 8'hC0};
    vecs[4] = '{1'b0, 20'h00002, 16'h1234, 1, 0, 22'h000001, 8'h34};
    vecs[5] = '{1'b1, 20'h00007, 16'h9876, 0, 0, 22'h010003, 8'h98};

    // Reset state, with both requesters already asking
    rst = 1'b1; sd_ack = 1'b0; sd_dst = 1'b0; sd_data = '0;
    z_cs = 1'b1; z_addr = 17'h00010; p_cs = 1'b1; p_addr = 20'h00020;
    fixed_en = 1'b0; ack_dly = 1; dst_dly = 1;
    repeat (2) step();
    chk("rst_sd_req", 32'(sd_req), 32'd0);
    chk("rst_sd_addr", 32'(sd_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_z80_ok", 32'(z_ok), 32'd0);
    chk("rst_pcm_ok", 32'(p_ok), 32'd0);
    chk("rst_z80_dout", 32'(z_dout), 32'd0);
    chk("rst_pcm_dout", 32'(p_dout), 32'd0);

    // Tie at reset release: PCM first, then Z80
    req_log.delete();
    rst = 1'b0;
    n = 0;
    while (!(z_ok && p_ok) && n < 80) begin step(); n++; end
    chk("tie1_both_ok", 32'(z_ok && p_ok), 32'd1);
    chk("tie1_first_pcm", 32'(req_log.size() > 0 ? req_log[0] : 22'h3FFFFF), 32'h010010);
    chk("tie1_second_z80", 32'(req_log.size() > 1 ? req_log[1] : 22'h3FFFFF), 32'h000008);
    chk("tie1_z80_dout", 32'(z_dout), 32'(exp_z80(17'h00010)));
    chk("tie1_pcm_dout", 32'(p_dout), 32'(exp_pcm(20'h00020)));
    z_cs = 1'b0; p_cs = 1'b0;
    repeat (3) step();
    req_log.delete();
    z_addr = 17'h00030; p_addr = 20'h00040; z_cs = 1'b1; p_cs = 1'b1;
    n = 0;
    while (!(z_ok && p_ok) && n < 80) begin step(); n++; end
    chk("tie2_first_pcm", 32'(req_log.size() > 0 ? req_log[0] : 22'h3FFFFF), 32'h010020);
    chk("tie2_second_z80", 32'(req_log.size() > 1 ? req_log[1] : 22'h3FFFFF), 32'h000018);
    z_cs = 1'b0; p_cs = 1'b0;
    repeat (3) step();

    // Vector table: address formation, byte select, latency, same-cycle ack+dst
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // PCM address moves during WAIT: old fetch completes, no OK, then refetch
    fixed_en = 1'b0; ack_dly = 1; dst_dly = 4;
    p_addr = 20'h00010; p_cs = 1'b1; #1;
    wait_req("mv_req1");
    chk("mv_sdaddr1", 32'(sd_addr), 32'h010008);
    n = 0;
    while (rs_phase != 2 && n < 20) begin step(); n++; end
    step();
    chk("mv_in_wait", 32'(busy && !sd_req), 32'd1);
    p_addr = 20'h00012;
    n = 0;
    while (dst_cyc != cyc && n < 20) begin step(); n++; end
    step();
    chk("mv_no_ok_after_dst", 32'(p_ok), 32'd0);
    wait_req("mv_req2");
    chk("mv_sdaddr2", 32'(sd_addr), 32'h010009);
    wait_ok(1'b1, "mv_ok2");
    chk("mv_dout2", 32'(p_dout), 32'(exp_pcm(20'h00012)));

    // Reset in WAIT while PCM holds a hit; then a late strobe must be ignored
    resp_en = 1'b0;
    z_addr = 17'h00050; z_cs = 1'b1; #1;
    wait_req("rw_req");
    sd_ack = 1'b1;
    step();
    chk("rw_busy_wait", 32'(busy), 32'd1);
    chk("rw_pcm_ok_before", 32'(p_ok), 32'd1);
    #2; rst = 1'b1; #1;
    chk("rw_busy_async", 32'(busy), 32'd0);
    chk("rw_sd_req_async", 32'(sd_req), 32'd0);
    chk("rw_pcm_ok_async", 32'(p_ok), 32'd0);
    chk("rw_z80_ok_async", 32'(z_ok), 32'd0);
    z_cs = 1'b0; p_cs = 1'b0;
    step();
    rst = 1'b0;
    sd_dst = 1'b1; sd_data = 16'hFFFF;
    step();
    chk("rw_late_dst_busy", 32'(busy), 32'd0);
    chk("rw_late_dst_z80", 32'(z_dout), 32'd0);
    chk("rw_late_dst_pcm", 32'(p_dout), 32'd0);
    chk("rw_late_dst_req", 32'(sd_req), 32'd0);
    resp_en = 1'b1; rs_phase = 0;

    // Drop and re-raise Z80 cs on the same address
    ack_dly = 1; dst_dly = 1;
    z_addr = 17'h00060; z_cs = 1'b1; #1;
    wait_ok(1'b0, "hit_first_ok");
    z_cs = 1'b0;
    repeat (3) step();
    z_cs = 1'b1; #1;
`ifdef RAIZING_SNDARB_HIT_EN
    chk("hit_ok_same_cycle", 32'(z_ok), 32'd1);
    chk("hit_dout", 32'(z_dout), 32'(exp_z80(17'h00060)));
    step();
    chk("hit_no_req", 32'(sd_req), 32'd0);
    chk("hit_not_busy", 32'(busy), 32'd0);
`else
    chk("nohit_ok_low", 32'(z_ok), 32'd0);
    step();
    chk("nohit_new_req", 32'(sd_req), 32'd1);
    chk("nohit_sdaddr", 32'(sd_addr), 32'h000030);
    wait_ok(1'b0, "nohit_ok");
`endif
    z_cs = 1'b0;
    step();

    // Randomized traffic against the ROM model
    do_reset();
    fixed_en = 1'b0; rand_dly = 1'b1;
    zw = 0; pw = 0; zprev = z_addr; pprev = p_addr;
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) z_cs = ~z_cs;
      if ($urandom_range(0, 9) == 0) p_cs = ~p_cs;
      if ($urandom_range(0, 11) == 0)
        z_addr = 17'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 17'h1FFF0 : 17'h0);
      if ($urandom_range(0, 11) == 0)
        p_addr = 20'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 20'hFFFF0 : 20'h0);
      #1;
      if (z_ok) chk("rnd_z80_dout", 32'(z_dout), 32'(exp_z80(z_addr)));
      if (p_ok) chk("rnd_pcm_dout", 32'(p_dout), 32'(exp_pcm(p_addr)));
      if (z_ok && zw > 0) chk("rnd_z80_wait", 32'(zw <= 40), 32'd1);
      if (p_ok && pw > 0) chk("rnd_pcm_wait", 32'(pw <= 40), 32'd1);
      if (!z_cs || z_ok || z_addr != zprev) zw = 0; else zw++;
      if (!p_cs || p_ok || p_addr != pprev) pw = 0; else pw++;
      if (zw > 40) begin chk("rnd_z80_starved", 32'(zw), 32'd40); zw = 0; end
      if (pw > 40) begin chk("rnd_pcm_starved", 32'(pw), 32'd40); pw = 0; end
      zprev = z_addr; pprev = p_addr;
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
